tea_iter_core: RTL and testbench

- Iterative, parametrised TEA encrypt/decrypt engine. Replaces the single-cycle combinational TEA datapath with a registered round loop that processes UNROLL rounds per clock.
- Data uses a valid/ready handshake on both sides. The key is loaded over a 64-bit side port, two halves per key.
- Sits between the block-buffer front end and the output packer; one block in flight at a time.

---
 rtl/tea_pkg.sv | 36 +++
 rtl/tea_iter_core_if.sv | 33 +++
 rtl/tea_round.sv | 44 ++++
 rtl/tea_iter_core.sv | 148 ++++++++++++++
 tb/tb_tea_iter_core.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tea_pkg.sv
// Shared constants, types and helpers for the iterative TEA engine.
package tea_pkg;

    localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // TEA mixing function; the right shift is logical.
    function automatic logic [31:0] tea_f(input logic [31:0] x,
                                          input logic [31:0] sum,
                                          input logic [31:0] ka,
                                          input logic [31:0] kb);
        return ((x << 4) + ka) ^ (x + sum) ^ ((x >> 5) + kb);
    endfunction

    function automatic logic [31:0] byteswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Byte-swap each 32-bit word in place; word order is unchanged.
    function automatic logic [63:0] wordswap64(input logic [63:0] x);
        return {byteswap32(x[63:32]), byteswap32(x[31:0])};
    endfunction

    function automatic logic [127:0] wordswap128(input logic [127:0] x);
        return {wordswap64(x[127:64]), wordswap64(x[63:0])};
    endfunction

endpackage

// File: rtl/tea_iter_core_if.sv
// Key side-port, input and output handshakes of the TEA engine.
interface tea_iter_core_if;

    logic        key_we;
    logic        key_sel;
    logic [63:0] key_data;
    logic        key_ready;
    logic        key_loaded;

    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [63:0] in_data;

    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    logic        busy;

    // Upstream/downstream side driving the engine.
    modport master (
        output key_we, key_sel, key_data, in_valid, in_mode, in_data, out_ready,
        input  key_ready, key_loaded, in_ready, out_valid, out_data, busy
    );

    // The engine itself.
    modport slave (
        input  key_we, key_sel, key_data, in_valid, in_mode, in_data, out_ready,
        output key_ready, key_loaded, in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/tea_round.sv
// One combinational TEA round, encrypt or decrypt selected by mode_i.
module tea_round
    import tea_pkg::*;
(
    input  logic [63:0]  v_i,
    input  logic [31:0]  sum_i,
    input  logic [127:0] key_i,
    input  logic         mode_i,
    output logic [63:0]  v_o,
    output logic [31:0]  sum_o
);

    logic [31:0] k0, k1, k2, k3;
    logic [31:0] v0, v1;
    logic [31:0] v0_n, v1_n, sum_n;

    assign k0 = key_i[127:96];
    assign k1 = key_i[95:64];
    assign k2 = key_i[63:32];
    assign k3 = key_i[31:0];
    assign v0 = v_i[63:32];
    assign v1 = v_i[31:0];

    // Encrypt adds DELTA before mixing; decrypt mixes with the current sum and
    // undoes the halves in reverse order before stepping sum back.
    always_comb begin
        sum_n = sum_i;
        v0_n  = v0;
        v1_n  = v1;
        if (mode_i == MODE_ENC) begin
            sum_n = sum_i + TEA_DELTA;
            v0_n  = v0 + tea_f(v1, sum_n, k0, k1);
            v1_n  = v1 + tea_f(v0_n, sum_n, k2, k3);
        end else begin
            v1_n  = v1 - tea_f(v0, sum_i, k2, k3);
            v0_n  = v0 - tea_f(v1_n, sum_i, k0, k1);
            sum_n = sum_i - TEA_DELTA;
        end
    end

    assign v_o   = {v0_n, v1_n};
    assign sum_o = sum_n;

endmodule

// File: rtl/tea_iter_core.sv
// Iterative TEA engine: UNROLL rounds per clock, one block in flight.
module tea_iter_core
    import tea_pkg::*;
#(
    parameter int ROUNDS     = 32,
    parameter int UNROLL     = 1,
    parameter bit SWAP_BYTES = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    tea_iter_core_if.slave bus
);

    localparam int CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS + 1) : 1;
    localparam logic [63:0] DEC_SUM_FULL = 64'(ROUNDS) * 64'(TEA_DELTA);
    localparam logic [31:0] DEC_SUM = DEC_SUM_FULL[31:0];

    generate
        if (ROUNDS < 1 || UNROLL < 1 || (ROUNDS % UNROLL) != 0) begin : g_bad_params
            $error("tea_iter_core: ROUNDS must be >= 1 and a multiple of UNROLL");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [63:0]        v_q, v_d;
    logic [31:0]        sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic [127:0]       key_q;
    logic [127:0]       blk_key_q;
    logic               hi_flag_q, lo_flag_q;

    logic               idle;
    logic               key_loaded;
    logic               accept;
    logic               key_wr;
    logic [63:0]        key_word;

    logic [63:0]        v_chain   [UNROLL+1];
    logic [31:0]        sum_chain [UNROLL+1];

    assign idle       = (state_q == IDLE);
    assign key_loaded = hi_flag_q & lo_flag_q;
    assign accept     = idle & key_loaded & bus.in_valid;
    assign key_wr     = idle & bus.key_we;
    assign key_word   = SWAP_BYTES ? wordswap64(bus.key_data) : bus.key_data;

    // Round units chained in series; the block key is frozen at accept time.
    assign v_chain[0]   = v_q;
    assign sum_chain[0] = sum_q;
    generate
        for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
            tea_round u_round (
                .v_i   (v_chain[gi]),
                .sum_i (sum_chain[gi]),
                .key_i (blk_key_q),
                .mode_i(mode_q),
                .v_o   (v_chain[gi+1]),
                .sum_o (sum_chain[gi+1])
            );
        end
    endgenerate

    // Key register and half-loaded flags; a high-half write invalidates the low half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q     <= '0;
            blk_key_q <= '0;
            hi_flag_q <= 1'b0;
            lo_flag_q <= 1'b0;
        end else begin
            if (accept) begin
                blk_key_q <= key_q;
            end
            if (key_wr) begin
                if (bus.key_sel == 1'b0) begin
                    key_q[127:64] <= key_word;
                    hi_flag_q     <= 1'b1;
                    lo_flag_q     <= 1'b0;
                end else begin
                    key_q[63:0]   <= key_word;
                    lo_flag_q     <= 1'b1;
                end
            end
        end
    end

    // Datapath and FSM state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            v_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_ENC;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state: load on accept, iterate in RUN, hold the result in DONE.
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    v_d     = SWAP_BYTES ? wordswap64(bus.in_data) : bus.in_data;
                    mode_d  = bus.in_mode;
                    cnt_d   = '0;
                    sum_d   = (bus.in_mode == MODE_DEC) ? DEC_SUM : 32'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                v_d   = v_chain[UNROLL];
                sum_d = sum_chain[UNROLL];
                cnt_d = cnt_q + CNT_W'(UNROLL);
                if (cnt_q + CNT_W'(UNROLL) == CNT_W'(ROUNDS)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.key_ready  = idle;
    assign bus.key_loaded = key_loaded;
    assign bus.in_ready   = idle & key_loaded;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_data   = SWAP_BYTES ? wordswap64(v_q) : v_q;
    assign bus.busy       = ~idle;

endmodule

// File: tb/tb_tea_iter_core.sv
// Bench for tea_iter_core: three instances (UNROLL=1, UNROLL=4, UNROLL=2 with
// byte swapping), table of vectors plus hand-written corner-case sequences.
module tb_tea_iter_core;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        key_we_a     [3];
    logic        key_sel_a    [3];
    logic [63:0] key_data_a   [3];
    logic        in_valid_a   [3];
    logic        in_mode_a    [3];
    logic [63:0] in_data_a    [3];
    logic        out_ready_a  [3];
    logic        key_ready_a  [3];
    logic        key_loaded_a [3];
    logic        in_ready_a   [3];
    logic        out_valid_a  [3];
    logic [63:0] out_data_a   [3];
    logic        busy_a       [3];

    int errors = 0;
    int checks = 0;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            tea_iter_core_if bus ();
            assign bus.key_we    = key_we_a[gi];
            assign bus.key_sel   = key_sel_a[gi];
            assign bus.key_data  = key_data_a[gi];
            assign bus.in_valid  = in_valid_a[gi];
            assign bus.in_mode   = in_mode_a[gi];
            assign bus.in_data   = in_data_a[gi];
            assign bus.out_ready = out_ready_a[gi];
            assign key_ready_a[gi]  = bus.key_ready;
            assign key_loaded_a[gi] = bus.key_loaded;
            assign in_ready_a[gi]   = bus.in_ready;
            assign out_valid_a[gi]  = bus.out_valid;
            assign out_data_a[gi]   = bus.out_data;
            assign busy_a[gi]       = bus.busy;
            tea_iter_core #(
                .ROUNDS    (32),
                .UNROLL    ((gi == 1) ? 4 : (gi == 2) ? 2 : 1),
                .SWAP_BYTES(gi == 2)
            ) u_dut (
                .clk(clk),
                .rst(rst),
                .bus(bus)
            );
        end
    endgenerate

    function automatic int lat_of(input int d);
        return (d == 1) ? 8 : (d == 2) ? 16 : 32;
    endfunction

    // Reference TEA encryption, straight from the classic C loop.
    function automatic logic [63:0] ref_enc(input logic [127:0] k, input logic [63:0] v);
        logic [31:0] v0 = v[63:32];
        logic [31:0] v1 = v[31:0];
        logic [31:0] s  = 32'd0;
        for (int r = 0; r < 32; r++) begin
            s  = s + 32'h9E3779B9;
            v0 = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
            v1 = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
        end
        return {v0, v1};
    endfunction

    function automatic logic [31:0] bs32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction
    function automatic logic [63:0] bs64(input logic [63:0] x);
        return {bs32(x[63:32]), bs32(x[31:0])};
    endfunction
    function automatic logic [127:0] bs128(input logic [127:0] x);
        return {bs64(x[127:64]), bs64(x[63:0])};
    endfunction

    // Expected ciphertext as seen on the ports of instance d.
    function automatic logic [63:0] exp_enc(input int d, input logic [127:0] k, input logic [63:0] p);
        if (d == 2) return bs64(ref_enc(bs128(k), bs64(p)));
        return ref_enc(k, p);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_key(input int d, input logic [127:0] k);
        @(negedge clk);
        key_we_a[d] = 1'b1; key_sel_a[d] = 1'b0; key_data_a[d] = k[127:64];
        @(negedge clk);
        key_sel_a[d] = 1'b1; key_data_a[d] = k[63:0];
        @(negedge clk);
        key_we_a[d] = 1'b0; key_data_a[d] = {$urandom, $urandom};
    endtask

    // Returns at the negedge that follows the accepting clock edge.
    task automatic start_block(input int d, input logic mode, input logic [63:0] din);
        int n = 0;
        @(negedge clk);
        in_valid_a[d] = 1'b1; in_mode_a[d] = mode; in_data_a[d] = din;
        while (!in_ready_a[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) check("accept_timeout", 1'b0, 1'b1);
        @(negedge clk);
        in_valid_a[d] = 1'b0; in_mode_a[d] = $urandom_range(0, 1); in_data_a[d] = {$urandom, $urandom};
    endtask

    task automatic wait_valid(input int d, input string name, input int lat);
        int k = 0;
        while (!out_valid_a[d] && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({name, "_latency"}, 128'(k), 128'(lat));
    endtask

    task automatic finish_block(input int d, input string name, input logic [63:0] exp);
        wait_valid(d, name, lat_of(d));
        check({name, "_data"}, out_data_a[d], exp);
        out_ready_a[d] = 1'b1;
        @(negedge clk);
        out_ready_a[d] = 1'b0;
        check({name, "_idle_after"}, {out_valid_a[d], busy_a[d]}, 2'b00);
    endtask

    typedef struct {
        int           d;
        logic         mode;
        logic [127:0] key;
        logic [63:0]  din;
        logic [63:0]  exp;
    } vec_t;

    localparam logic [63:0] KAT_CT = 64'h41EA3A0A_94BAA940;

    initial begin
        vec_t         vecs [8];
        logic [127:0] k1, k2;
        logic [63:0]  p1, p2, ct;
        logic         saw_valid;

        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t         vecs [8];
        logic [127:0] k1, k2;
        logic [63:0]  p1, p2, ct;
        logic         saw_valid;

        for (int d = 0; d < 3; d++) begin
            key_we_a[d] = 1'b0; key_sel_a[d] = 1'b0; key_data_a[d] = '0;
            in_valid_a[d] = 1'b0; in_mode_a[d] = 1'b0; in_data_a[d] = '0;
            out_ready_a[d] = 1'b0;
        end

        // Reset state of every instance
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_outputs_%0d", d),
                  {key_ready_a[d], key_loaded_a[d], in_ready_a[d], out_valid_a[d], busy_a[d]},
                  5'b10000);
        end
        @(negedge clk);
        rst = 1'b0;

        k1 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        p1 = 64'hDEADBEEF_01234567;
        k2 = {$urandom, $urandom, $urandom, $urandom};
        p2 = {$urandom, $urandom};

        vecs[0] = '{0, 1'b0, 128'd0, 64'd0,  KAT_CT};
        vecs[1] = '{0, 1'b1, 128'd0, KAT_CT, 64'd0};
        vecs[2] = '{1, 1'b0, 128'd0, 64'd0,  KAT_CT};
        vecs[3] = '{1, 1'b0, k2, p2, exp_enc(1, k2, p2)};
        vecs[4] = '{1, 1'b1, k2, exp_enc(1, k2, p2), p2};
        vecs[5] = '{0, 1'b0, k1, p1, exp_enc(0, k1, p1)};
        vecs[6] = '{2, 1'b0, k1, p1, exp_enc(2, k1, p1)};
        vecs[7] = '{2, 1'b1, k1, exp_enc(2, k1, p1), p1};

        for (int i = 0; i < 8; i++) begin
            load_key(vecs[i].d, vecs[i].key);
            start_block(vecs[i].d, vecs[i].mode, vecs[i].din);
            finish_block(vecs[i].d, $sformatf("vec%0d", i), vecs[i].exp);
            $display("vec%0d unit=%0d mode=%0d in=%h out=%h", i, vecs[i].d, vecs[i].mode,
                     vecs[i].din, out_data_a[vecs[i].d]);
        end

        // Decrypt starts from ROUNDS*DELTA
        load_key(0, 128'd0);
        start_block(0, 1'b1, KAT_CT);
        check("dec_initial_sum", g_dut[0].u_dut.sum_q, 32'hC6EF3720);
        finish_block(0, "dec_kat", 64'd0);
        $display("dec_kat out=%h", out_data_a[0]);

        // Back-pressure in DONE: output stable, no accept, key writes ignored
        load_key(0, k1);
        start_block(0, 1'b0, p1);
        wait_valid(0, "hold", 32);
        ct = exp_enc(0, k1, p1);
        saw_valid = 1'b1;
        in_valid_a[0] = 1'b1; in_data_a[0] = p2;
        key_we_a[0] = 1'b1; key_sel_a[0] = 1'b0; key_data_a[0] = 64'hFFFF_0000_FFFF_0000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_data_a[0] !== ct || !out_valid_a[0] || in_ready_a[0] || !key_loaded_a[0])
                saw_valid = 1'b0;
        end
        check("hold_stable", saw_valid, 1'b1);
        in_valid_a[0] = 1'b0; key_we_a[0] = 1'b0;
        out_ready_a[0] = 1'b1;
        @(negedge clk);
        out_ready_a[0] = 1'b0;
        check("hold_release", {out_valid_a[0], busy_a[0], in_ready_a[0]}, 3'b001);
        start_block(0, 1'b0, p2);
        finish_block(0, "hold_key_kept", exp_enc(0, k1, p2));
        $display("hold sequence out=%h", out_data_a[0]);

        // Key write coincident with accept: block uses the old key
        load_key(1, k1);
        @(negedge clk);
        in_valid_a[1] = 1'b1; in_mode_a[1] = 1'b0; in_data_a[1] = p1;
        key_we_a[1] = 1'b1; key_sel_a[1] = 1'b0; key_data_a[1] = k2[127:64];
        check("coincident_ready", in_ready_a[1], 1'b1);
        @(negedge clk);
        in_valid_a[1] = 1'b0; key_we_a[1] = 1'b0;
        check("coincident_flags", {busy_a[1], key_loaded_a[1]}, 2'b10);
        finish_block(1, "coincident", exp_enc(1, k1, p1));
        load_key(1, k2);
        start_block(1, 1'b0, p1);
        finish_block(1, "new_key", exp_enc(1, k2, p1));
        $display("coincident sequence out=%h", out_data_a[1]);

        // Fresh reset, then only the high half: no accept until the low half lands
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        key_we_a[0] = 1'b1; key_sel_a[0] = 1'b0; key_data_a[0] = k2[127:64];
        @(negedge clk);
        key_we_a[0] = 1'b0;
        in_valid_a[0] = 1'b1; in_mode_a[0] = 1'b0; in_data_a[0] = p1;
        @(negedge clk);
        check("half_key_blocked", {key_loaded_a[0], in_ready_a[0], busy_a[0]}, 3'b000);
        @(negedge clk);
        check("half_key_still_idle", busy_a[0], 1'b0);
        key_we_a[0] = 1'b1; key_sel_a[0] = 1'b1; key_data_a[0] = k2[63:0];
        @(negedge clk);
        key_we_a[0] = 1'b0;
        check("full_key_ready", {key_loaded_a[0], in_ready_a[0], busy_a[0]}, 3'b110);
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        check("full_key_accepted", busy_a[0], 1'b1);
        finish_block(0, "half_key", exp_enc(0, k2, p1));
        $display("key load sequence out=%h", out_data_a[0]);

        // Asynchronous reset in the middle of RUN
        start_block(0, 1'b0, p2);
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrun_reset", {out_valid_a[0], busy_a[0], key_loaded_a[0], key_ready_a[0], in_ready_a[0]},
              5'b00010);
        @(negedge clk);
        rst = 1'b0;
        in_valid_a[0] = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (out_valid_a[0] || busy_a[0]) saw_valid = 1'b1;
        end
        in_valid_a[0] = 1'b0;
        check("no_output_after_reset", saw_valid, 1'b0);
        $display("midrun reset sequence done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
